// File: rtl/nibble_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// addseq_pkg
// Shared definitions for the nibble-serial adder sequencer:
//   state_t  - sequencer FSM states
//   NIB_W    - width of the shared nibble adder
//   clog2    - index-width helper (never returns less than 1)
// ---------------------------------------------------------------------------
package addseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;

    // Ceiling log2, clamped to 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// ---------------------------------------------------------------------------
// nibble_add_seq_if
// Handshake bundle between producer/consumer and the sequencer.
//   in_valid/in_ready   operand handshake (a, b, cin[, sub])
//   out_valid/out_ready result handshake (sum, cout)
//   busy                sequencer holds an operation
// Optional macro: ADDSEQ_SUB_EN adds the 'sub' request line.
// Modports: master = producer/consumer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface nibble_add_seq_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDSEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
`ifdef ADDSEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef ADDSEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/nibble_add_seq_nibble_add.sv
// ---------------------------------------------------------------------------
// nibble_add
// Purely combinational 4-bit ripple-carry adder: {cout, s} = a + b + cin.
//   a, b  in   nibble operands
//   cin   in   carry-in
//   s     out  nibble sum
//   cout  out  carry-out
// ---------------------------------------------------------------------------
module nibble_add
    import addseq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] carry;

    // Explicit ripple chain: propagate/generate per bit.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_add_seq.sv
// ---------------------------------------------------------------------------
// nibble_add_seq
// Adds two WIDTH-bit operands through one shared 4-bit adder, one nibble per
// clock, LSB nibble first. Latency is NIB cycles from accept to out_valid;
// one operation completes every NIB+2 cycles.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of nibble_add_seq_if:
//            in_valid/in_ready, a, b, cin  operand handshake
//            out_valid/out_ready, sum, cout result handshake
//            busy                         high in RUN or DONE
// Optional macro: ADDSEQ_SUB_EN - 'sub' request turns the operation into
//   a - b (op_b inverted, carry-in forced to 1, cout = no-borrow).
// ---------------------------------------------------------------------------
module nibble_add_seq
    import addseq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    nibble_add_seq_if.slave  bus
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = clog2(NIB);

    // Reject widths that are not whole nibbles or are narrower than 8 bits.
    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_add_seq: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] nib_idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_s;
    logic             nib_co;
    logic             last_nib;

    // Select the operand nibbles addressed by nib_idx.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (nib_idx == IDX_W'(i)) begin
                nib_a = op_a[i*NIB_W +: NIB_W];
                nib_b = op_b[i*NIB_W +: NIB_W];
            end
        end
    end

    assign last_nib = (nib_idx == IDX_W'(NIB - 1));

    // The only adder in the datapath.
    nibble_add u_nibble_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_co)
    );

    // Sequencer FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            carry       <= 1'b0;
            nib_idx     <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone accepts.
                    if (bus.in_valid) begin
                        op_a    <= bus.a;
`ifdef ADDSEQ_SUB_EN
                        // Subtract as a + ~b + 1; cin is ignored for subtracts.
                        op_b    <= bus.sub ? ~bus.b : bus.b;
                        carry   <= bus.sub | bus.cin;
`else
                        op_b    <= bus.b;
                        carry   <= bus.cin;
`endif
                        nib_idx <= '0;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (nib_idx == IDX_W'(i)) begin
                            sum_q[i*NIB_W +: NIB_W] <= nib_s;
                        end
                    end
                    carry <= nib_co;
                    if (last_nib) begin
                        nib_idx     <= '0;
                        cout_q      <= nib_co;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        nib_idx <= nib_idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    // sum/cout hold until the consumer takes the result.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Handshake status decodes straight from state; no input-to-output path.
    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_add_seq
// Bench for nibble_add_seq: a WIDTH=16 instance for directed and randomized
// handshake traffic, and a WIDTH=32 instance for back-to-back random ops.
// A behavioural model (plain arithmetic on the accepted operands plus the
// expected result edge) is checked against both DUTs on every falling edge.
// Honours ADDSEQ_SUB_EN when defined.
// ---------------------------------------------------------------------------
module tb_nibble_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n16 = 1'b1;
    logic rst_n32 = 1'b1;

    nibble_add_seq_if #(.WIDTH(16)) bus16 ();
    nibble_add_seq_if #(.WIDTH(32)) bus32 ();

    nibble_add_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n16), .bus(bus16));
    nibble_add_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n32), .bus(bus32));

    logic sub16;
    logic sub32;
`ifdef ADDSEQ_SUB_EN
    assign sub16 = bus16.sub;
    assign sub32 = bus32.sub;
`else
    assign sub16 = 1'b0;
    assign sub32 = 1'b0;
`endif

    int     n_vec = 0;
    int     n_bad = 0;
    longint edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    // Model state per DUT (0 = 16-bit, 1 = 32-bit).
    bit          pend[2]     = '{0, 0};
    longint      due[2]      = '{0, 0};
    longint      last_acc[2] = '{-1, -1};
    logic [31:0] m_sum[2]    = '{32'd0, 32'd0};
    logic        m_cout[2]   = '{1'b0, 1'b0};
    int          acc_cnt[2]  = '{0, 0};
    bit          b2b[2]      = '{0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Per-cycle compare plus model update for the handshake due at the next edge.
    task automatic monitor(input int id, input int w, input logic rstn,
                           input logic iv, input logic ir, input logic ov,
                           input logic ordy, input logic bsy,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] s, input logic ci,
                           input logic sb, input logic co);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] full;
        bit          exp_ov;
        int          nib;
        nib  = w / 4;
        mask = (64'd1 << w) - 64'd1;
        if (!rstn) begin
            chk("reset_out_valid", 64'(ov), 64'd0);
            chk("reset_sum", 64'(s), 64'd0);
            chk("reset_cout", 64'(co), 64'd0);
            chk("reset_in_ready", 64'(ir), 64'd1);
            chk("reset_busy", 64'(bsy), 64'd0);
            pend[id]     = 1'b0;
            last_acc[id] = -1;
            return;
        end
        exp_ov = pend[id] && (edge_cnt >= due[id]);
        chk("out_valid", 64'(ov), 64'(exp_ov));
        chk("in_ready", 64'(ir), 64'(!pend[id]));
        chk("busy", 64'(bsy), 64'(pend[id]));
        if (exp_ov) begin
            chk("sum", 64'(s), 64'(m_sum[id]));
            chk("cout", 64'(co), 64'(m_cout[id]));
        end
        if (exp_ov && ordy) begin
            pend[id] = 1'b0;
        end else if (!pend[id] && iv) begin
            bb   = sb ? (~{32'd0, b} & mask) : {32'd0, b};
            full = {32'd0, a} + bb + (sb ? 64'd1 : 64'(ci));
            m_sum[id]  = 32'(full & mask);
            m_cout[id] = full[w];
            due[id]    = edge_cnt + 1 + longint'(nib);
            pend[id]   = 1'b1;
            acc_cnt[id]++;
            if (b2b[id] && last_acc[id] >= 0) begin
                chk("accept_spacing", 64'(edge_cnt + 1 - last_acc[id]), 64'(nib + 2));
            end
            last_acc[id] = edge_cnt + 1;
        end
    endtask

    always @(negedge clk) begin
        monitor(0, 16, rst_n16, bus16.in_valid, bus16.in_ready, bus16.out_valid,
                bus16.out_ready, bus16.busy, 32'(bus16.a), 32'(bus16.b),
                32'(bus16.sum), bus16.cin, sub16, bus16.cout);
        monitor(1, 32, rst_n32, bus32.in_valid, bus32.in_ready, bus32.out_valid,
                bus32.out_ready, bus32.busy, bus32.a, bus32.b,
                bus32.sum, bus32.cin, sub32, bus32.cout);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the 16-bit result; k = edges waited.
    task automatic wait_ov16(output int k);
        k = 0;
        while (!bus16.out_valid && k < 50) begin
            step(1);
            k++;
        end
        chk("out_valid_timeout16", 64'(bus16.out_valid), 64'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb);
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = ci;
`ifdef ADDSEQ_SUB_EN
        bus16.sub      = sb;
`else
        if (sb) $display("note: subtract requested without ADDSEQ_SUB_EN");
`endif
        bus16.in_valid = 1'b1;
        step(1);
        bus16.in_valid = 1'b0;
    endtask

    task automatic run16();
        int k;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
        bus16.sub       = 1'b0;
`endif
        #2 rst_n16 = 1'b0;
        step(3);
        rst_n16 = 1'b1;
        step(1);
        chk("idle_in_ready", 64'(bus16.in_ready), 64'd1);

        // Carry ripples through every nibble.
        bus16.out_ready = 1'b1;
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_ov16(k);
        chk("carry_latency", 64'(k), 64'd4);
        chk("carry_sum", 64'(bus16.sum), 64'h0000);
        chk("carry_cout", 64'(bus16.cout), 64'd1);
        step(1);
        chk("drain_in_ready", 64'(bus16.in_ready), 64'd1);
        chk("drain_out_valid", 64'(bus16.out_valid), 64'd0);

        // Carry-in, in_valid held through RUN with new operands, then backpressure.
        bus16.out_ready = 1'b0;
        bus16.a         = 16'h1234;
        bus16.b         = 16'h4321;
        bus16.cin       = 1'b1;
        bus16.in_valid  = 1'b1;
        step(1);
        bus16.a   = 16'hAAAA;
        bus16.b   = 16'h5555;
        bus16.cin = 1'b0;
        step(1);
        chk("run_in_ready", 64'(bus16.in_ready), 64'd0);
        wait_ov16(k);
        chk("cin_sum", 64'(bus16.sum), 64'h5556);
        chk("cin_cout", 64'(bus16.cout), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("bp_out_valid", 64'(bus16.out_valid), 64'd1);
            chk("bp_sum", 64'(bus16.sum), 64'h5556);
            chk("bp_in_ready", 64'(bus16.in_ready), 64'd0);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        step(1);
        chk("bp_release_in_ready", 64'(bus16.in_ready), 64'd1);

        // Reset during nibble 2.
        op16(16'h1111, 16'h2222, 1'b0, 1'b0);
        step(2);
        rst_n16 = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
        chk("midrst_sum", 64'(bus16.sum), 64'd0);
        chk("midrst_in_ready", 64'(bus16.in_ready), 64'd1);
        step(2);
        rst_n16 = 1'b1;
        step(1);
        op16(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_ov16(k);
        chk("post_rst_sum", 64'(bus16.sum), 64'h0003);
        step(1);

`ifdef ADDSEQ_SUB_EN
        op16(16'h0005, 16'h0007, 1'b0, 1'b1);
        bus16.sub = 1'b0;
        wait_ov16(k);
        chk("sub_neg_sum", 64'(bus16.sum), 64'hFFFE);
        chk("sub_neg_cout", 64'(bus16.cout), 64'd0);
        step(1);
        op16(16'h0007, 16'h0005, 1'b1, 1'b1);
        bus16.sub = 1'b0;
        wait_ov16(k);
        chk("sub_pos_sum", 64'(bus16.sum), 64'h0002);
        chk("sub_pos_cout", 64'(bus16.cout), 64'd1);
        step(1);
`endif

        // Random traffic with random valid and backpressure.
        for (int i = 0; i < 300; i++) begin
            bus16.a         = 16'($urandom);
            bus16.b         = 16'($urandom);
            bus16.cin       = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            bus16.sub       = 1'($urandom);
`endif
            bus16.in_valid  = 1'($urandom);
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        step(10);
    endtask

    task automatic run32();
        int cyc;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.cin       = 1'b0;
        bus32.out_ready = 1'b1;
`ifdef ADDSEQ_SUB_EN
        bus32.sub       = 1'b0;
`endif
        #2 rst_n32 = 1'b0;
        step(3);
        rst_n32 = 1'b1;
        step(1);
        b2b[1] = 1'b1;
        bus32.in_valid = 1'b1;
        cyc = 0;
        while (acc_cnt[1] < 100 && cyc < 3000) begin
            bus32.a   = $urandom;
            bus32.b   = $urandom;
            bus32.cin = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            bus32.sub = 1'($urandom);
`endif
            step(1);
            cyc++;
        end
        chk("b2b_ops_done", 64'(acc_cnt[1] >= 100), 64'd1);
        bus32.in_valid = 1'b0;
        step(15);
        b2b[1] = 1'b0;
    endtask

    initial begin
        fork
            run16();
            run32();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
